// File: rtl/slow_clk_ctrl_if.sv
// Config port bundle for slow_clk_ctrl: valid/ready divisor transfer.
// Master offers cfg_div with cfg_valid; slave answers with cfg_ready.
interface slow_clk_ctrl_if #(
   parameter int CNT_W = 16
);
   logic             cfg_valid;
   logic [CNT_W-1:0] cfg_div;
   logic             cfg_ready;

   modport master (
      output cfg_valid,
      output cfg_div,
      input  cfg_ready
   );

   modport slave (
      input  cfg_valid,
      input  cfg_div,
      output cfg_ready
   );
endinterface

// File: rtl/slow_clk_ctrl.sv
// Fast-to-slow clock divider with glitch-free divisor update and clean stop.
// Optional SLOW_CLK_CTRL_TICK_CNT_EN adds a 32-bit slow_tick counter output.
module slow_clk_ctrl #(
   parameter int               CNT_W       = 16,
   parameter logic [CNT_W-1:0] DEFAULT_DIV = 16'hFFFF
) (
   input  logic           fast_clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic           stop,
   slow_clk_ctrl_if.slave cfg,
   output logic           slow_clk,
   output logic           slow_tick,
   output logic           busy,
`ifdef SLOW_CLK_CTRL_TICK_CNT_EN
   output logic [31:0]    tick_cnt,
`endif
   output logic           err_div
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      STOPPING
   } state_t;

   localparam logic [CNT_W-1:0] ONE = 1;

   state_t           state, state_d;
   logic [CNT_W-1:0] cnt, cnt_d;
   logic [CNT_W-1:0] div_active, act_d;
   logic [CNT_W-1:0] div_pending, dpend_d;
   logic             pending, pend_d;
   logic             ready, ready_d;
   logic             clk_d, tick_d, busy_d, err_d;
   logic             wrap;

   assign cfg.cfg_ready = ready;
   assign wrap = (cnt == div_active - ONE);

   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      clk_d   = slow_clk;
      tick_d  = 1'b0;
      act_d   = div_active;
      dpend_d = div_pending;
      pend_d  = pending;
      ready_d = ready;
      err_d   = 1'b0;
      unique case (state)
         IDLE: begin
            cnt_d = '0;
            clk_d = 1'b0;
            if (start && !stop)
               state_d = RUN;
         end
         RUN: begin
            if (stop && !slow_clk) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (wrap) begin
               cnt_d  = '0;
               clk_d  = ~slow_clk;
               tick_d = 1'b1;
               // stop landing on the falling toggle parks immediately
               if (stop)
                  state_d = IDLE;
            end else begin
               cnt_d = cnt + ONE;
               if (stop)
                  state_d = STOPPING;
            end
         end
         STOPPING: begin
            if (wrap) begin
               cnt_d   = '0;
               clk_d   = 1'b0;
               tick_d  = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt + ONE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            clk_d   = 1'b0;
         end
      endcase
      // new divisor only lands on a toggle so no half-period is cut short
      if (pending && (state == IDLE || tick_d)) begin
         act_d   = div_pending;
         pend_d  = 1'b0;
         ready_d = 1'b1;
      end
      if (cfg.cfg_valid && ready) begin
         if (cfg.cfg_div != '0) begin
            dpend_d = cfg.cfg_div;
            pend_d  = 1'b1;
            ready_d = 1'b0;
         end else begin
            err_d = 1'b1;
         end
      end
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge fast_clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         div_active  <= DEFAULT_DIV;
         div_pending <= '0;
         pending     <= 1'b0;
         ready       <= 1'b1;
         slow_clk    <= 1'b0;
         slow_tick   <= 1'b0;
         busy        <= 1'b0;
         err_div     <= 1'b0;
      end else begin
         state       <= state_d;
         cnt         <= cnt_d;
         div_active  <= act_d;
         div_pending <= dpend_d;
         pending     <= pend_d;
         ready       <= ready_d;
         slow_clk    <= clk_d;
         slow_tick   <= tick_d;
         busy        <= busy_d;
         err_div     <= err_d;
      end
   end

`ifdef SLOW_CLK_CTRL_TICK_CNT_EN
   always_ff @(posedge fast_clk or negedge rst_n) begin
      if (!rst_n)
         tick_cnt <= '0;
      else if (state == IDLE && state_d == RUN)
         tick_cnt <= '0;
      else if (tick_d)
         tick_cnt <= tick_cnt + 32'd1;
   end
`endif

endmodule

// File: tb/tb_slow_clk_ctrl.sv
// Randomized bench for slow_clk_ctrl against a half-period countdown model.
// Tracks remaining cycles per half-period rather than an up-counter.
module tb_slow_clk_ctrl;

   localparam int               CNT_W = 16;
   localparam logic [CNT_W-1:0] DDIV  = 16'd7;

   logic fast_clk = 1'b0;
   logic rst_n;
   logic start, stop;
   logic slow_clk, slow_tick, busy, err_div;
`ifdef SLOW_CLK_CTRL_TICK_CNT_EN
   logic [31:0] tick_cnt;
`endif

   slow_clk_ctrl_if #(.CNT_W(CNT_W)) cfg_if ();

   slow_clk_ctrl #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DDIV)
   ) dut (
      .fast_clk  (fast_clk),
      .rst_n     (rst_n),
      .start     (start),
      .stop      (stop),
      .cfg       (cfg_if.slave),
      .slow_clk  (slow_clk),
      .slow_tick (slow_tick),
      .busy      (busy),
`ifdef SLOW_CLK_CTRL_TICK_CNT_EN
      .tick_cnt  (tick_cnt),
`endif
      .err_div   (err_div)
   );

   always #5 fast_clk = ~fast_clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   // model: 0 idle, 1 run, 2 stopping; m_left = cycles to next toggle
   int          m_st, m_left, m_div, m_pdiv;
   bit          m_clk, m_tick, m_pend, m_rdy, m_err;
   int unsigned m_tcnt;

   task automatic model_reset();
      m_st = 0; m_left = 0; m_div = DDIV; m_pdiv = 0;
      m_clk = 0; m_tick = 0; m_pend = 0; m_rdy = 1; m_err = 0;
      m_tcnt = 0;
   endtask

   task automatic model_step();
      bit s, p, v, tk, idle0, pend0, rdy0;
      int d, nd;
      s = start; p = stop; v = cfg_if.cfg_valid; d = cfg_if.cfg_div;
      idle0 = (m_st == 0); pend0 = m_pend; rdy0 = m_rdy;
      nd = m_pend ? m_pdiv : m_div;
      tk = 0;
      case (m_st)
         0: if (s && !p) begin
            m_st = 1; m_left = nd; m_tcnt = 0;
         end
         1: if (p && !m_clk) begin
            m_st = 0;
         end else if (m_left == 1) begin
            tk = 1; m_clk = !m_clk; m_left = nd;
            if (p) m_st = 0;
         end else begin
            m_left--;
            if (p) m_st = 2;
         end
         default: if (m_left == 1) begin
            tk = 1; m_clk = 0; m_st = 0;
         end else begin
            m_left--;
         end
      endcase
      if (pend0 && (idle0 || tk)) begin
         m_div = m_pdiv; m_pend = 0; m_rdy = 1;
      end
      m_err = 0;
      if (v && rdy0) begin
         if (d != 0) begin
            m_pdiv = d; m_pend = 1; m_rdy = 0;
         end else begin
            m_err = 1;
         end
      end
      m_tick = tk;
      if (tk) m_tcnt++;
   endtask

   task automatic compare();
      chk("slow_clk", slow_clk, m_clk);
      chk("slow_tick", slow_tick, m_tick);
      chk("busy", busy, m_st != 0);
      chk("cfg_ready", cfg_if.cfg_ready, m_rdy);
      chk("err_div", err_div, m_err);
`ifdef SLOW_CLK_CTRL_TICK_CNT_EN
      chk("tick_cnt", tick_cnt, m_tcnt);
`endif
   endtask

   task automatic cycle();
      @(posedge fast_clk);
      if (rst_n) model_step();
      else model_reset();
      #1;
      compare();
   endtask

   task automatic drive(input bit s, input bit p, input bit v,
                        input logic [CNT_W-1:0] d);
      start = s; stop = p;
      cfg_if.cfg_valid = v; cfg_if.cfg_div = d;
      cycle();
   endtask

   task automatic wait_rise(input string tag);
      for (int n = 0; n < 200 && !(slow_clk && slow_tick); n++)
         drive(0, 0, 0, '0);
      chk(tag, slow_clk && slow_tick, 1'b1);
   endtask

   initial begin
      start = 0; stop = 0; rst_n = 0;
      cfg_if.cfg_valid = 0; cfg_if.cfg_div = '0;
      model_reset();
      repeat (3) cycle();
      #2 rst_n = 1;
      repeat (50) drive(0, 0, 0, '0);

      drive(0, 0, 1, 16'd4);
      drive(0, 0, 0, '0);
      drive(1, 0, 0, '0);
      repeat (80) drive(0, 0, 0, '0);

      wait_rise("basic_rise");
      drive(0, 0, 0, '0);
      drive(0, 0, 1, 16'd2);
      repeat (30) drive(0, 0, 0, '0);

      drive(0, 0, 1, '0);
      repeat (10) drive(0, 0, 0, '0);

      drive(0, 0, 1, 16'd6);
      repeat (30) drive(0, 0, 0, '0);
      wait_rise("stop_rise");
      drive(0, 0, 0, '0);
      drive(0, 1, 0, '0);
      repeat (20) drive(0, 0, 0, '0);
      drive(1, 1, 0, '0);
      repeat (5) drive(0, 0, 0, '0);

      for (int i = 0; i < 3000; i++)
         drive(($urandom % 20) == 0, ($urandom % 25) == 0,
               ($urandom % 4) == 0, CNT_W'($urandom % 6));

      repeat (20) drive(0, 1, 0, '0);
      drive(0, 0, 1, 16'd6);
      drive(0, 0, 0, '0);
      drive(1, 0, 0, '0);
      wait_rise("rst_rise");
      drive(0, 0, 1, 16'd3);
      #2 rst_n = 0;
      #1;
      chk("arst_clk", slow_clk, 1'b0);
      chk("arst_busy", busy, 1'b0);
      chk("arst_ready", cfg_if.cfg_ready, 1'b1);
      model_reset();
      cfg_if.cfg_valid = 0;
      repeat (2) cycle();
      #2 rst_n = 1;
      drive(1, 0, 0, '0);
      repeat (40) drive(0, 0, 0, '0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/slow_clk_ctrl.md
Name: slow_clk_ctrl

Overview:
- Run-time controller for the fast-to-slow clock division path. Generates a divided clock `slow_clk` and a one-cycle `slow_tick` strobe, both synchronous to `fast_clk`.
- Half-period is programmable through a valid/ready config port. New divisors are applied glitch-free, only at toggle boundaries.
- Start/stop sequencing guarantees `slow_clk` always parks low, with no runt pulses.
- Sits between the system config logic and every consumer of the slow clock/enable.

Parameters:
- CNT_W, 16, width of the divisor and the internal counter.
- DEFAULT_DIV, 16'hFFFF, half-period in `fast_clk` cycles loaded at reset.

Ports:
- fast_clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  level/pulse request to begin dividing.
- stop  in  1  request to stop; `slow_clk` parks low.
- cfg_valid  in  1  new divisor offered.
- cfg_div  in  CNT_W  new half-period in `fast_clk` cycles; 0 is illegal.
- cfg_ready  out  1  controller can accept a divisor.
- slow_clk  out  1  divided clock (registered level).
- slow_tick  out  1  one-cycle pulse coincident with each `slow_clk` toggle.
- busy  out  1  high whenever state is not IDLE.
- err_div  out  1  one-cycle pulse when `cfg_div == 0` is offered.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, counter=0, div_active=DEFAULT_DIV, pending=0.
  - slow_clk=0, slow_tick=0, cfg_ready=1, err_div=0, busy=0.
- Reset mid-operation: all of the above take effect immediately, including `slow_clk` dropping to 0.
- States: IDLE, RUN, STOPPING.
- IDLE:
  - counter held at 0, slow_clk=0.
  - `start=1` -> RUN next cycle.
- RUN / STOPPING counting:
  - counter increments by 1 per cycle.
  - Wrap cycle is `counter == div_active-1`. On it: counter<=0, slow_clk<=~slow_clk, slow_tick<=1.
  - Half-period = div_active cycles; full period = 2*div_active cycles.
  - div_active=1 -> toggle every cycle.
  - First rising edge of slow_clk occurs div_active cycles after entering RUN.
- `stop` handling:
  - RUN with slow_clk=0 -> IDLE next cycle.
  - RUN with slow_clk=1 -> STOPPING.
  - STOPPING continues counting; at the wrap (falling toggle, slow_tick=1) -> IDLE.
- Simultaneous `start` and `stop`: stop wins; IDLE stays IDLE.
- `start` in RUN or STOPPING is ignored.
- Config handshake:
  - Transfer occurs when `cfg_valid & cfg_ready`.
  - If cfg_div != 0: div_pending<=cfg_div, pending<=1, cfg_ready<=0 next cycle.
  - If cfg_div == 0: no store, err_div pulses 1 cycle, cfg_ready stays 1.
- Pending apply:
  - In IDLE: applied the cycle after acceptance.
  - In RUN/STOPPING: applied on the next wrap cycle, so the new half-period starts from counter=0. The current half-period is never truncated or extended.
  - On apply: div_active<=div_pending, pending<=0, cfg_ready<=1 next cycle.
- Config accepted in the same cycle as a wrap is not applied at that wrap; it waits for the following wrap.
- busy is registered and mirrors the state (RUN or STOPPING).

Optional Feature:
- Macro: SLOW_CLK_CTRL_TICK_CNT_EN.
- Defined:
  - Adds output `tick_cnt` [31:0]: free-running count of slow_tick pulses.
  - Reset to 0; wraps 32'hFFFFFFFF -> 0.
  - Cleared on each IDLE->RUN transition.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset then idle: rst_n low 3 cycles, release -> slow_clk=0, cfg_ready=1, busy=0; `start` held 0 for 50 cycles -> no slow_tick.
- Basic divide: cfg_div=4 accepted in IDLE, then start -> busy=1; slow_clk rises 4 cycles after entering RUN; period 8 cycles; slow_tick on every toggle; 5 full periods checked.
- Glitch-free update: running with div=4, cfg_div=2 offered mid half-period -> current half-period completes at 4 cycles, subsequent half-periods are 2 cycles; cfg_ready low from acceptance until the cycle after the wrap.
- Illegal config: cfg_div=0 with cfg_valid -> err_div=1 for exactly 1 cycle, div_active unchanged, cfg_ready remains 1.
- Stop while high: div=6, stop asserted 2 cycles after a rising toggle -> STOPPING; slow_clk falls 4 cycles later with slow_tick; IDLE next; busy=0. start+stop same cycle in IDLE -> stays IDLE.
- Async reset mid-run: rst_n asserted while slow_clk=1 with a pending config -> slow_clk=0 immediately; after release div_active=DEFAULT_DIV and pending cleared.
